// File: rtl/conv_rescale.sv
// Requantizes LANES signed accumulators to signed 8-bit lanes: scale, rounding shift, saturate, 3-stage pipeline.
// Optional build macro CONV_RESCALE_RELU_EN clamps negative results to zero (saturation range becomes [0, 127]).
module conv_rescale #(
    parameter int LANES     = 40,
    parameter int ACC_W     = 32,
    parameter int MULT_W    = 16,
    parameter int SHIFT_W   = 5,
    parameter int FRAME_LEN = 64,
    localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [ACC_W*LANES-1:0]   acc_i,
    input  logic [MULT_W-1:0]        mult_i,
    input  logic [SHIFT_W-1:0]       shift_i,
    output logic                     valid_o,
    output logic [8*LANES-1:0]       data_o,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         beat_cnt
);
    localparam int PROD_W = ACC_W + MULT_W + 1;
    localparam int RND_W  = PROD_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(127);
    localparam logic signed [RND_W-1:0] SAT_MIN = -RND_W'(128);

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
        if (c == LAST_BEAT) begin
            next_cnt = {CNT_W{1'b0}};
        end else begin
            next_cnt = c + CNT_W'(1);
        end
    endfunction

    function automatic logic [7:0] sat8(input logic signed [RND_W-1:0] v);
`ifdef CONV_RESCALE_RELU_EN
        if (v[RND_W-1]) begin
            sat8 = 8'h00;
        end else if (v > SAT_MAX) begin
            sat8 = 8'h7f;
        end else begin
            sat8 = v[7:0];
        end
`else
        if (v > SAT_MAX) begin
            sat8 = 8'h7f;
        end else if (v < SAT_MIN) begin
            sat8 = 8'h80;
        end else begin
            sat8 = v[7:0];
        end
`endif
    endfunction

    logic [CNT_W-1:0]          in_cnt_r;
    logic [MULT_W-1:0]         cfg_mult_r;
    logic [SHIFT_W-1:0]        cfg_shift_r;
    logic                      first_s;
    logic [MULT_W-1:0]         mult_s;
    logic [SHIFT_W-1:0]        shift_s;
    logic signed [PROD_W-1:0]  prod_s [LANES];
    logic signed [PROD_W-1:0]  prod_r [LANES];
    logic [SHIFT_W-1:0]        sh1_r;
    logic                      v1_r;
    logic signed [RND_W-1:0]   rnd_s;
    logic signed [RND_W-1:0]   rsum_s [LANES];
    logic signed [RND_W-1:0]   r_r [LANES];
    logic                      v2_r;
    logic [8*LANES-1:0]        sat_s;
    logic [CNT_W-1:0]          beat_idx_s;
    logic                      valid_o_r;
    logic [8*LANES-1:0]        data_o_r;
    logic                      frame_done_r;
    logic [CNT_W-1:0]          beat_cnt_r;

    // The first beat of a frame uses the incoming config directly; it is latched for the rest of the frame.
    assign first_s = valid_i && (in_cnt_r == {CNT_W{1'b0}});
    assign mult_s  = first_s ? mult_i  : cfg_mult_r;
    assign shift_s = first_s ? shift_i : cfg_shift_r;

    // Stage 1 multiply: zero-extended scale keeps the product signed.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_s[k] = PROD_W'($signed(acc_i[ACC_W*k +: ACC_W])) * PROD_W'($signed({1'b0, mult_s}));
        end
    end

    // Stage 1 registers, config latch and input frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r        <= 1'b0;
            sh1_r       <= {SHIFT_W{1'b0}};
            in_cnt_r    <= {CNT_W{1'b0}};
            cfg_mult_r  <= {MULT_W{1'b0}};
            cfg_shift_r <= {SHIFT_W{1'b0}};
            for (int k = 0; k < LANES; k++) begin
                prod_r[k] <= {PROD_W{1'b0}};
            end
        end else begin
            v1_r  <= valid_i;
            sh1_r <= shift_s;
            for (int k = 0; k < LANES; k++) begin
                prod_r[k] <= prod_s[k];
            end
            if (valid_i) begin
                in_cnt_r <= next_cnt(in_cnt_r);
            end else begin
                in_cnt_r <= in_cnt_r;
            end
            if (first_s) begin
                cfg_mult_r  <= mult_i;
                cfg_shift_r <= shift_i;
            end else begin
                cfg_mult_r  <= cfg_mult_r;
                cfg_shift_r <= cfg_shift_r;
            end
        end
    end

    // Stage 2 rounding shift, one bit wider than the product so the half-LSB add cannot overflow.
    always_comb begin
        rnd_s = {RND_W{1'b0}};
        if (sh1_r == {SHIFT_W{1'b0}}) begin
            rnd_s = {RND_W{1'b0}};
        end else begin
            rnd_s = $signed({{(RND_W-1){1'b0}}, 1'b1} << (sh1_r - SHIFT_W'(1)));
        end
        for (int k = 0; k < LANES; k++) begin
            rsum_s[k] = (RND_W'(prod_r[k]) + rnd_s) >>> sh1_r;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_r[k] <= {RND_W{1'b0}};
            end
        end else begin
            v2_r <= v1_r;
            for (int k = 0; k < LANES; k++) begin
                r_r[k] <= rsum_s[k];
            end
        end
    end

    // Stage 3 saturation of every lane.
    always_comb begin
        sat_s = {(8*LANES){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            sat_s[8*k +: 8] = sat8(r_r[k]);
        end
    end

    // Index the next output beat will carry: beat_cnt already counts beats emitted so far.
    assign beat_idx_s = valid_o_r ? next_cnt(beat_cnt_r) : beat_cnt_r;

    // Output registers; data holds between valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o_r    <= 1'b0;
            data_o_r     <= {(8*LANES){1'b0}};
            frame_done_r <= 1'b0;
            beat_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            valid_o_r    <= v2_r;
            frame_done_r <= v2_r && (beat_idx_s == LAST_BEAT);
            beat_cnt_r   <= beat_idx_s;
            if (v2_r) begin
                data_o_r <= sat_s;
            end else begin
                data_o_r <= data_o_r;
            end
        end
    end

    assign valid_o    = valid_o_r;
    assign data_o     = data_o_r;
    assign frame_done = frame_done_r;
    assign beat_cnt   = beat_cnt_r;
endmodule

// File: tb/tb_conv_rescale.sv
// Directed bench for conv_rescale with LANES=2, FRAME_LEN=4; expected values are hand-computed.
module tb_conv_rescale;
    localparam int LANES     = 2;
    localparam int ACC_W     = 32;
    localparam int MULT_W    = 16;
    localparam int SHIFT_W   = 5;
    localparam int FRAME_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [63:0] acc_i;
    logic [15:0] mult_i;
    logic [4:0]  shift_i;
    logic        valid_o;
    logic [15:0] data_o;
    logic        frame_done;
    logic [1:0]  beat_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    conv_rescale #(
        .LANES(LANES), .ACC_W(ACC_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .acc_i(acc_i), .mult_i(mult_i),
        .shift_i(shift_i), .valid_o(valid_o), .data_o(data_o), .frame_done(frame_done),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
`ifdef CONV_RESCALE_RELU_EN
        if (v < 0) return 8'h00;
`endif
        if (v > 127) return 8'h7f;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic logic [31:0] pk(input int l1, input int l0);
        return {16'h0000, sat(l1), sat(l0)};
    endfunction

    task automatic drive(input int l1, input int l0, input int m, input int sh);
        valid_i = 1'b1;
        acc_i   = {l1, l0};
        mult_i  = m[15:0];
        shift_i = sh[4:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; acc_i = 64'd0; mult_i = 16'd0; shift_i = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", valid_o, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_done", frame_done, 32'd0);
        check("rst_beat", beat_cnt, 32'd0);

        // identity scale, latency of three cycles
        @(negedge clk); drive(100, -5, 1, 0);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk); check("lat_early", valid_o, 32'd0);
        @(negedge clk);
        check("id_valid", valid_o, 32'd1);
        check("id_data", data_o, pk(100, -5));
        check("id_beat", beat_cnt, 32'd0);
        @(negedge clk);
        check("hold_valid", valid_o, 32'd0);
        check("hold_data", data_o, pk(100, -5));

        // rounding with mult=3 shift=2; second beat's new config must be ignored
        do_reset();
        @(negedge clk); drive(-6, 5, 3, 2);
        @(negedge clk); drive(0, 2, 7, 7);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk);
        check("rnd0_data", data_o, pk(-4, 4));
        check("rnd0_beat", beat_cnt, 32'd0);
        @(negedge clk);
        check("rnd1_valid", valid_o, 32'd1);
        check("rnd1_data", data_o, pk(0, 2));
        check("rnd1_beat", beat_cnt, 32'd1);

        // shift=3: 104>>3=13, -16>>>3=-2, half cases 8>>3=1 and 0>>3=0
        do_reset();
        @(negedge clk); drive(100, -20, 1, 3);
        @(negedge clk); drive(4, -4, 1, 3);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk); check("sh3_data0", data_o, pk(13, -2));
        @(negedge clk); check("sh3_data1", data_o, pk(1, 0));

        // saturation; second beat tries a huge config that must be ignored mid-frame
        do_reset();
        @(negedge clk); drive(1000, -1000, 1, 0);
        @(negedge clk); drive(int'(32'h7fff_ffff), int'(32'h8000_0000), 65535, 31);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk); check("sat_data0", data_o, pk(1000, -1000));
        @(negedge clk); check("sat_data1", data_o, pk(1000, -1000));

        // two frames back-to-back, mult change at beat 2 ignored, picked up at beat 4
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                int b;
                int m;
                b = c - 3;
                m = (b < 4) ? 1 : 2;
                check($sformatf("frm_valid%0d", b), valid_o, 32'd1);
                check($sformatf("frm_data%0d", b), data_o, pk(b * m, 10 * (b + 1) * m));
                check($sformatf("frm_beat%0d", b), beat_cnt, 32'(b % 4));
                check($sformatf("frm_done%0d", b), frame_done, (b % 4 == 3) ? 32'd1 : 32'd0);
            end
            if (c < 8) begin
                drive(c, 10 * (c + 1), (c < 2) ? 1 : 2, 0);
            end else begin
                valid_i = 1'b0;
            end
        end
        @(negedge clk);
        check("frm_end_valid", valid_o, 32'd0);
        check("frm_end_done", frame_done, 32'd0);
        check("frm_end_beat", beat_cnt, 32'd0);

        // reset with two beats in flight, then relatch config
        @(negedge clk); drive(7, 7, 9, 0);
        @(negedge clk); drive(7, 7, 9, 0);
        @(negedge clk); valid_i = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_valid", valid_o, 32'd0);
        check("mid_rst_data", data_o, 32'd0);
        check("mid_rst_beat", beat_cnt, 32'd0);
        check("mid_rst_done", frame_done, 32'd0);
        @(negedge clk);
        check("mid_rst_valid2", valid_o, 32'd0);
        drive(3, 2, 5, 0);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk); check("mid_rst_valid3", valid_o, 32'd0);
        @(negedge clk);
        check("relatch_valid", valid_o, 32'd1);
        check("relatch_data", data_o, pk(15, 10));
        check("relatch_beat", beat_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/conv_rescale.md
# conv_rescale

Requantization stage between each convolution layer's accumulator output and the rescaled-result consumers (result selector, cycle-count probe). Converts a vector of LANES signed 32-bit accumulators into LANES signed 8-bit values. Each lane is multiplied by a per-frame scale, then passes through a rounding arithmetic right shift and saturation. Output is a 3-stage pipelined vector with valid and a frame-done pulse; one instance per layer (LANES = 40, 36*32, 36).

## Interface
Parameters:
- LANES, 40, number of parallel accumulator lanes
- ACC_W, 32, signed accumulator width per lane
- MULT_W, 16, unsigned scale multiplier width
- SHIFT_W, 5, right-shift amount width (0..31)
- FRAME_LEN, 64, output beats per frame

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  input beat qualifier
- acc_i  in  ACC_W*LANES  accumulators, lane k at bits [ACC_W*k +: ACC_W], signed
- mult_i  in  MULT_W  scale multiplier, unsigned
- shift_i  in  SHIFT_W  right-shift amount
- valid_o  out  1  output beat qualifier (the layer's *_valid_o_rescaled)
- data_o  out  8*LANES  rescaled lanes, lane k at [8*k +: 8], signed
- frame_done  out  1  one-cycle pulse coincident with the last valid_o beat of a frame
- beat_cnt  out  log2(FRAME_LEN) bits, min 1  output beats accepted in the current frame

## Operation
- Config latch: mult_i/shift_i captured into cfg registers when valid_i=1 and input beat counter in_cnt=0 (first beat of a frame). That beat and all later beats of the frame use the latched values. Mid-frame changes on mult_i/shift_i are ignored.
- in_cnt increments on each valid_i and wraps FRAME_LEN-1 -> 0.
- S1: prod = signed(acc) * {0, mult} (ACC_W+MULT_W+1 bits, signed).
- S2: if shift=0, r = prod; else r = (prod + (1 << (shift-1))) >>> shift, with the add done one bit wider so it cannot overflow. Rounding is round-half-up toward +inf.
- S3: saturate r to [-128, 127] → data_o lane.
- beat_cnt increments on each valid_o and wraps FRAME_LEN-1 -> 0. frame_done = valid_o && beat_cnt == FRAME_LEN-1.
- No backpressure: every valid_i beat produces exactly one valid_o beat.
- No FSM beyond the two frame counters (in_cnt, beat_cnt). Pipeline stages advance every cycle; valid bits shift alongside data.

## Timing
- Latency: valid_i at cycle N → valid_o/data_o at cycle N+3. Throughput: 1 beat/cycle, back-to-back allowed.
- Reset value of every output is 0: valid_o, data_o, frame_done, beat_cnt. in_cnt, cfg registers, and pipeline valid bits also reset to 0.
- Reset mid-frame: in-flight beats are discarded (no valid_o for them). Both counters return to 0. The next valid_i is treated as a first beat and relatches config.
- data_o holds its last value while valid_o=0. Consumers must qualify with valid_o.
- Gaps in valid_i do not affect counters. A frame may span any number of cycles.
- Frame boundary with back-to-back beats: last beat of frame F and first beat of frame F+1 in consecutive cycles. Each uses its own frame's config, since config travels with the pipeline (latched into S1 per beat).
- frame_done and the last valid_o assert in the same cycle. frame_done is never asserted without valid_o.

## Configuration
- Macro CONV_RESCALE_RELU_EN.
- Defined: S3 saturates to [0, 127], applying ReLU; negative results output 0.
- Undefined: S3 saturates to [-128, 127].
- Counters, latency and interface are identical in both builds.

## Test plan
- LANES=2, mult=1, shift=0; acc = {100, -5} → data_o = {100, -5} three cycles after valid_i.
- mult=3, shift=2; acc=5 → (15+2)>>2 = 4; acc=-6 → (-18+2)>>>2 = -4; acc=2 → (6+2)>>2 = 2.
- Saturation, mult=1, shift=0: acc=1000 → 127; acc=-1000 → -128, or 0 with CONV_RESCALE_RELU_EN.
- FRAME_LEN=4; 8 back-to-back beats with mult changed from 1 to 2 at beat 2 and beat 4 → beats 0-3 use 1, beats 4-7 use 2; frame_done at output beats 3 and 7; beat_cnt sequence 0,1,2,3,0,1,2,3.
- Assert rst for 1 cycle with 2 beats in flight → no valid_o for them; outputs 0 the cycle after reset; next beat relatches config and beat_cnt counts from 0.
- Random gapped valid_i, 1000 beats vs. reference model → exact match, valid_o count equals valid_i count.
